// File: rtl/baud_rate_generator_if.sv
// ============================================================================
// Module  : baud_rate_generator_if
// Brief   : Control/status bundle between the SPI register block and the
//           baud rate generator.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface baud_rate_generator_if;
    logic        cpol_i;
    logic        cphase_i;
    logic        spiswai_i;
    logic [1:0]  spi_mode_i;
    logic [2:0]  spr_i;
    logic [2:0]  sppr_i;
    logic        ss_i;
    logic        sclk_o;
    logic [11:0] BaudRateDivisor_o;
    logic        miso_receive_sclk_o;
    logic        miso_receive_sclk0_o;
    logic        mosi_send_sclk_o;
    logic        mosi_send_sclk0_o;

    modport master (
        output cpol_i, cphase_i, spiswai_i, spi_mode_i, spr_i, sppr_i, ss_i,
        input  sclk_o, BaudRateDivisor_o, miso_receive_sclk_o,
               miso_receive_sclk0_o, mosi_send_sclk_o, mosi_send_sclk0_o
    );

    modport slave (
        input  cpol_i, cphase_i, spiswai_i, spi_mode_i, spr_i, sppr_i, ss_i,
        output sclk_o, BaudRateDivisor_o, miso_receive_sclk_o,
               miso_receive_sclk0_o, mosi_send_sclk_o, mosi_send_sclk0_o
    );
endinterface

`default_nettype wire

// File: rtl/baud_rate_generator.sv
// ============================================================================
// Module  : baud_rate_generator
// Brief   : SPI master SCLK generator with sample/launch strobes. Optional
//           macro BRG_DIV_LATCH_EN freezes spr/sppr during a transfer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module baud_rate_generator (
    input  wire logic             PCLK,
    input  wire logic             PRESET,
    baud_rate_generator_if.slave  brg
);

    logic [2:0]  w_spr;
    logic [2:0]  w_sppr;
    logic [11:0] w_divisor;
    logic [10:0] w_half_m1;
    logic [10:0] r_count;
    logic        r_sclk;
    logic        w_active;
    logic        w_edge;
    logic        w_rise_next;
    logic        w_inv_phase;

    assign w_active = ~brg.ss_i &
                      ((brg.spi_mode_i == 2'b00) |
                       ((brg.spi_mode_i == 2'b01) & ~brg.spiswai_i));

`ifdef BRG_DIV_LATCH_EN
    logic [2:0] r_spr;
    logic [2:0] r_sppr;

    // Divisor fields only track the register block between transfers
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_spr  <= 3'd0;
            r_sppr <= 3'd0;
        end else if (!w_active) begin
            r_spr  <= brg.spr_i;
            r_sppr <= brg.sppr_i;
        end
    end

    assign w_spr  = r_spr;
    assign w_sppr = r_sppr;
`else
    assign w_spr  = brg.spr_i;
    assign w_sppr = brg.sppr_i;
`endif

    assign w_divisor = ({9'd0, w_sppr} + 12'd1) << ({1'b0, w_spr} + 4'd1);
    assign w_half_m1 = w_divisor[11:1] - 11'd1;

    // ">=" lets a shrinking divisor wrap the count instead of overrunning it
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_count <= 11'd0;
            r_sclk  <= 1'b0;
        end else if (!w_active) begin
            r_count <= 11'd0;
            r_sclk  <= brg.cpol_i;
        end else if (r_count >= w_half_m1) begin
            r_count <= 11'd0;
            r_sclk  <= ~r_sclk;
        end else begin
            r_count <= r_count + 11'd1;
        end
    end

    assign w_edge      = ~PRESET & w_active & (r_count == w_half_m1);
    assign w_rise_next = ~r_sclk;
    assign w_inv_phase = brg.cpol_i ^ brg.cphase_i;

    assign brg.sclk_o               = r_sclk;
    assign brg.BaudRateDivisor_o    = w_divisor;
    assign brg.miso_receive_sclk_o  = w_edge &  w_rise_next & ~w_inv_phase;
    assign brg.mosi_send_sclk0_o    = w_edge &  w_rise_next &  w_inv_phase;
    assign brg.mosi_send_sclk_o     = w_edge & ~w_rise_next & ~w_inv_phase;
    assign brg.miso_receive_sclk0_o = w_edge & ~w_rise_next &  w_inv_phase;

endmodule

`default_nettype wire

// File: tb/tb_baud_rate_generator.sv
// ============================================================================
// Module  : tb_baud_rate_generator
// Brief   : Randomized scoreboard bench for baud_rate_generator against an
//           edge-timing reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_baud_rate_generator;

    typedef struct {
        int         cyc;
        logic       sclk;
        logic [11:0] div;
        logic [3:0] stb;   // {miso_rx, miso_rx0, mosi_tx, mosi_tx0}
    } exp_t;

    logic PCLK = 1'b0;
    logic PRESET;
    baud_rate_generator_if bus ();

    baud_rate_generator dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .brg    (bus)
    );

    always #5 PCLK = ~PCLK;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t q[$];

    // Requested inputs for the next cycle
    logic       c_ss = 1'b1, c_spiswai = 1'b0, c_cpol = 1'b0, c_cpha = 1'b0;
    logic [1:0] c_mode = 2'b00;
    logic [2:0] c_spr = 3'd0, c_sppr = 3'd0;

    // Reference model: elapsed PCLKs since the last SCLK edge / activation
    int   m_elapsed;
    logic m_sclk;
    logic [2:0] m_spr, m_sppr;

    function automatic int divisor_of(input logic [2:0] spr, input logic [2:0] sppr);
        return (int'(sppr) + 1) * (2 ** (int'(spr) + 1));
    endfunction

    function automatic logic model_active();
        return !bus.ss_i && (bus.spi_mode_i == 2'b00 ||
                             (bus.spi_mode_i == 2'b01 && !bus.spiswai_i));
    endfunction

    function automatic int eff_div();
`ifdef BRG_DIV_LATCH_EN
        return divisor_of(m_spr, m_sppr);
`else
        return divisor_of(bus.spr_i, bus.sppr_i);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_elapsed = 0;
        m_sclk    = 1'b0;
        m_spr     = 3'd0;
        m_sppr    = 3'd0;
    endtask

    // Advance the model across one rising edge using the inputs the DUT saw
    task automatic model_update();
        int half;
        half = eff_div() / 2;
        if (!model_active()) begin
            m_elapsed = 0;
            m_sclk    = bus.cpol_i;
        end else if (m_elapsed + 1 >= half) begin
            m_elapsed = 0;
            m_sclk    = ~m_sclk;
        end else begin
            m_elapsed++;
        end
        if (!model_active()) begin
            m_spr  = bus.spr_i;
            m_sppr = bus.sppr_i;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        int   half;
        logic edge_next, rising, sample;
        half      = eff_div() / 2;
        edge_next = model_active() && (m_elapsed == half - 1);
        rising    = (m_sclk == 1'b0);
        // Sample edge is the leading edge when cpha=0; leading = away from cpol
        sample    = (rising == (bus.cpol_i == 1'b0)) ^ bus.cphase_i;
        e.cyc  = cyc;
        e.sclk = m_sclk;
        e.div  = 12'(eff_div());
        e.stb  = 4'b0000;
        if (edge_next) begin
            if (bus.cpol_i == bus.cphase_i) e.stb = sample ? 4'b1000 : 4'b0010;
            else                            e.stb = sample ? 4'b0100 : 4'b0001;
        end
        q.push_back(e);
    endtask

    task automatic apply_inputs();
        bus.ss_i       = c_ss;
        bus.spi_mode_i = c_mode;
        bus.spiswai_i  = c_spiswai;
        bus.cpol_i     = c_cpol;
        bus.cphase_i   = c_cpha;
        bus.spr_i      = c_spr;
        bus.sppr_i     = c_sppr;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge PCLK);
            cyc++;
            model_update();
            #1;
            apply_inputs();
            push_expected();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sclk"}, 32'(bus.sclk_o), 32'd0);
        chk({tag, "_strobes"}, 32'({bus.miso_receive_sclk_o, bus.miso_receive_sclk0_o,
                                    bus.mosi_send_sclk_o, bus.mosi_send_sclk0_o}), 32'd0);
    endtask

    // Monitor: every cycle the DUT presents a full output set
    initial begin
        exp_t e;
        forever begin
            @(negedge PCLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sclk", 32'(bus.sclk_o), 32'(e.sclk));
                chk("divisor", 32'(bus.BaudRateDivisor_o), 32'(e.div));
                chk("miso_receive_sclk", 32'(bus.miso_receive_sclk_o), 32'(e.stb[3]));
                chk("miso_receive_sclk0", 32'(bus.miso_receive_sclk0_o), 32'(e.stb[2]));
                chk("mosi_send_sclk", 32'(bus.mosi_send_sclk_o), 32'(e.stb[1]));
                chk("mosi_send_sclk0", 32'(bus.mosi_send_sclk0_o), 32'(e.stb[0]));
            end
        end
    end

    initial begin
        int wait_cnt;
        PRESET = 1'b1;
        c_cpol = 1'b1; c_cpha = 1'b1; c_sppr = 3'd0; c_spr = 3'd2;
        apply_inputs();
        #2;
        chk_reset_outputs("reset");
        @(posedge PCLK); #1;
        chk_reset_outputs("reset_hold");
        model_reset();
        PRESET = 1'b0;
        push_expected();

        // Test 1: divisor 8, idle high, first fall 4 PCLKs after ss falls
        run(3);
        c_ss = 1'b0;
        run(40);

        // Test 2: cpol=0 cpha=1, divisor 4
        c_ss = 1'b1; c_cpol = 1'b0; c_cpha = 1'b1; c_sppr = 3'd1; c_spr = 3'd0;
        run(3);
        c_ss = 1'b0;
        run(30);

        // Test 3: maximum divisor 2048
        c_ss = 1'b1; c_sppr = 3'd7; c_spr = 3'd7;
        run(3);
        c_ss = 1'b0;
        run(2100);

        // Test 4: wait/stop modes and ss gating
        c_ss = 1'b1; c_sppr = 3'd0; c_spr = 3'd0; c_cpol = 1'b1; c_cpha = 1'b0;
        run(3);
        c_ss = 1'b0; c_mode = 2'b01; c_spiswai = 1'b1; run(10);
        c_spiswai = 1'b0; run(20);
        c_mode = 2'b10; run(8);
        c_mode = 2'b11; run(8);
        c_mode = 2'b00; run(12);
        c_ss = 1'b1; run(6);

        // Test 5: divisor shrinks mid-period
        c_spr = 3'd7; c_sppr = 3'd0;
        run(3);
        c_ss = 1'b0;
        run(101);
        c_spr = 3'd0;
        run(300);
        c_ss = 1'b1;
        run(4);

        // Test 6: asynchronous reset mid-period
        c_ss = 1'b0; c_spr = 3'd1; c_sppr = 3'd2;
        run(17);
        @(posedge PCLK); #3;
        q.delete();
        PRESET = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge PCLK); #1;
        chk_reset_outputs("async_reset_hold");
        cyc++;
        model_reset();
        PRESET = 1'b0;
        push_expected();
        run(30);

        // Randomized transfers with occasional mid-transfer disturbances
        for (int t = 0; t < 40; t++) begin
            c_ss      = 1'b1;
            c_mode    = 2'b00;
            c_cpol    = 1'($urandom_range(0, 1));
            c_cpha    = 1'($urandom_range(0, 1));
            c_spr     = 3'($urandom_range(0, 3));
            c_sppr    = 3'($urandom_range(0, 7));
            c_spiswai = 1'($urandom_range(0, 1));
            run($urandom_range(1, 4));
            c_ss = 1'b0;
            for (int k = 0; k < 6; k++) begin
                run($urandom_range(5, 40));
                case ($urandom_range(0, 5))
                    0: c_spr  = 3'($urandom_range(0, 3));
                    1: c_sppr = 3'($urandom_range(0, 7));
                    2: c_mode = 2'($urandom_range(0, 3));
                    3: c_mode = 2'b00;
                    default: ;
                endcase
            end
        end
        c_ss = 1'b1;
        run(4);

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge PCLK);
            wait_cnt++;
        end
        @(negedge PCLK);
        @(posedge PCLK);
        chk("scoreboard_drain", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
